commit_trace_checker: RTL and testbench

- In-hardware consumer of the per-instruction commit stream: PC, register write, memory access and halt.
- Fetches one golden commit record per retired instruction from an expected-trace memory and compares the two field by field.
- Stops at the first divergence or at halt.
- Sits beside the processor core in the simulation/FPGA top. The core's retire logic drives its commit inputs; a ROM preloaded with golden records drives its gold port.

---
 rtl/commit_trace_pkg.sv | 60 ++++++
 rtl/commit_trace_checker_fifo.sv | 53 +++++
 rtl/commit_trace_checker.sv | 109 ++++++++++
 tb/tb_commit_trace_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace checker: golden/commit record
// layout, field offsets, FSM state encoding and the field-compare helper.
package commit_trace_pkg;

    localparam int REC_W = 71;

    // Field widths
    localparam int PC_W   = 16;
    localparam int WREG_W = 3;
    localparam int DAT_W  = 16;
    localparam int ADR_W  = 16;

    // Bit offsets inside a packed record (LSB of each field)
    localparam int HALT_B     = 0;
    localparam int MDATA_LSB  = 1;
    localparam int MADDR_LSB  = 17;
    localparam int MEMWR_B    = 33;
    localparam int MEMRD_B    = 34;
    localparam int WDATA_LSB  = 35;
    localparam int WREG_LSB   = 51;
    localparam int REGWR_B    = 54;
    localparam int PC_LSB     = 55;

    // Record layout, MSB to LSB, matches the offsets above
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              regwrite;
        logic [WREG_W-1:0] wreg;
        logic [DAT_W-1:0]  wdata;
        logic              memread;
        logic              memwrite;
        logic [ADR_W-1:0]  maddr;
        logic [DAT_W-1:0]  mdata;
        logic              halt;
    } commit_rec_t;

    // FSM state encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // Field-wise compare; optional fields are masked by the golden flags
    function automatic logic rec_match(input commit_rec_t c, input commit_rec_t g);
        logic ok;
        ok = (c.pc == g.pc) && (c.regwrite == g.regwrite) &&
             (c.memread == g.memread) && (c.memwrite == g.memwrite) &&
             (c.halt == g.halt);
        if (g.regwrite)
            ok = ok && (c.wreg == g.wreg) && (c.wdata == g.wdata);
        if (g.memread || g.memwrite)
            ok = ok && (c.maddr == g.maddr);
        if (g.memwrite)
            ok = ok && (c.mdata == g.mdata);
        return ok;
    endfunction

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Small synchronous FIFO holding packed commit events until the checker
// has fetched the matching golden record. Depth must be a power of two.
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 71
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares the core's retire stream against golden records fetched one at
// a time from an expected-trace memory; stops at first divergence or halt.
module commit_trace_checker
    import commit_trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int REC_W      = 71
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cm_valid,
    input  logic [15:0]      cm_pc,
    input  logic             cm_regwrite,
    input  logic [2:0]       cm_wreg,
    input  logic [15:0]      cm_wdata,
    input  logic             cm_memread,
    input  logic             cm_memwrite,
    input  logic [15:0]      cm_maddr,
    input  logic [15:0]      cm_mdata,
    input  logic             cm_halt,
    output logic             cm_ready,
    output logic             gold_req,
    output logic [15:0]      gold_addr,
    input  logic             gold_valid,
    input  logic [REC_W-1:0] gold_rec,
    output logic [15:0]      inst_count,
    output logic             done,
    output logic             mismatch,
    output logic [15:0]      mismatch_idx
);
    logic [2:0]       state;
    logic             terminal;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             overflow;
    logic [REC_W-1:0] cm_bits;
    logic [REC_W-1:0] head_bits;
    commit_rec_t      head;
    commit_rec_t      gold_q;

    assign cm_bits  = {cm_pc, cm_regwrite, cm_wreg, cm_wdata, cm_memread,
                       cm_memwrite, cm_maddr, cm_mdata, cm_halt};
    assign head     = commit_rec_t'(head_bits);

    // Once finished the checker keeps accepting and silently drops events
    assign terminal = (state == S_DONE) || (state == S_ERR);
    assign cm_ready = terminal || !full;
    assign push     = cm_valid && !full && !terminal;
    assign overflow = cm_valid && full && !terminal;
    assign pop      = (state == S_CMP);

    assign gold_req  = (state == S_REQ);
    assign gold_addr = inst_count;
    assign done      = (state == S_DONE);

    commit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cm_bits),
        .dout  (head_bits),
        .full  (full),
        .empty (empty)
    );

    // Checker FSM, progress counter and sticky divergence report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            inst_count   <= '0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
        end else if (overflow) begin
            // A dropped event breaks the trace alignment for good
            state        <= S_ERR;
            mismatch     <= 1'b1;
            mismatch_idx <= inst_count;
        end else begin
            case (state)
                S_IDLE: if (!empty) state <= S_REQ;
                S_REQ:  state <= S_WAIT;
                S_WAIT: if (gold_valid) state <= S_CMP;
                S_CMP: begin
                    if (!rec_match(head, gold_q)) begin
                        state        <= S_ERR;
                        mismatch     <= 1'b1;
                        mismatch_idx <= inst_count;
                    end else begin
                        inst_count <= inst_count + 16'd1;
                        state      <= gold_q.halt ? S_DONE : S_IDLE;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Capture the golden record only when the checker is waiting for it
    always_ff @(posedge clk) begin
        if (state == S_WAIT && gold_valid) gold_q <= commit_rec_t'(gold_rec);
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker: table of single-record compare
// cases plus hand-written multi-record, overflow and reset sequences.
module tb_commit_trace_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cm_valid = 1'b0;
    logic [15:0] cm_pc = '0;
    logic        cm_regwrite = 1'b0;
    logic [2:0]  cm_wreg = '0;
    logic [15:0] cm_wdata = '0;
    logic        cm_memread = 1'b0;
    logic        cm_memwrite = 1'b0;
    logic [15:0] cm_maddr = '0;
    logic [15:0] cm_mdata = '0;
    logic        cm_halt = 1'b0;
    logic        cm_ready;
    logic        gold_req;
    logic [15:0] gold_addr;
    logic        gold_valid;
    logic [70:0] gold_rec;
    logic [15:0] inst_count;
    logic        done;
    logic        mismatch;
    logic [15:0] mismatch_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_trace_checker #(.FIFO_DEPTH(4), .REC_W(71)) dut (
        .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc),
        .cm_regwrite(cm_regwrite), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
        .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
        .cm_maddr(cm_maddr), .cm_mdata(cm_mdata), .cm_halt(cm_halt),
        .cm_ready(cm_ready), .gold_req(gold_req), .gold_addr(gold_addr),
        .gold_valid(gold_valid), .gold_rec(gold_rec),
        .inst_count(inst_count), .done(done), .mismatch(mismatch),
        .mismatch_idx(mismatch_idx)
    );

    // Golden ROM model with programmable latency, shares rst with the DUT
    logic [70:0] rom [0:15];
    int          lat = 1;
    logic        pend;
    int          cnt;
    logic [15:0] raddr;
    int          req_cnt;
    logic [15:0] req_addr [0:15];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gold_valid <= 1'b0;
            gold_rec   <= '0;
            pend       <= 1'b0;
            cnt        <= 0;
            raddr      <= '0;
            req_cnt    <= 0;
        end else begin
            gold_valid <= 1'b0;
            if (gold_req) begin
                if (req_cnt < 16) req_addr[req_cnt] <= gold_addr;
                req_cnt <= req_cnt + 1;
                if (lat <= 1) begin
                    gold_valid <= 1'b1;
                    gold_rec   <= rom[gold_addr[3:0]];
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    raddr <= gold_addr;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    gold_valid <= 1'b1;
                    gold_rec   <= rom[raddr[3:0]];
                    pend       <= 1'b0;
                end
                cnt <= cnt - 1;
            end
        end
    end

    function automatic logic [70:0] mk(input logic [15:0] pc, input logic rw,
                                       input logic [2:0] wr, input logic [15:0] wd,
                                       input logic mr, input logic mw,
                                       input logic [15:0] ma, input logic [15:0] md,
                                       input logic h);
        return {pc, rw, wr, wd, mr, mw, ma, md, h};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cm_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic [70:0] rec);
        {cm_pc, cm_regwrite, cm_wreg, cm_wdata, cm_memread, cm_memwrite,
         cm_maddr, cm_mdata, cm_halt} = rec;
        cm_valid = 1'b1;
        @(negedge clk);
        cm_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!(done || mismatch) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!(done || mismatch)) check({"timeout_", name}, 32'd1, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [70:0] gold;
        logic [70:0] cm;
        logic        exp_mm;
        logic        exp_done;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic [70:0] g, input logic [70:0] c,
                       input logic mm, input logic dn, input logic [15:0] ic);
        vec_t v;
        v.name = n; v.gold = g; v.cm = c; v.exp_mm = mm; v.exp_done = dn; v.exp_cnt = ic;
        vq.push_back(v);
    endtask

    initial begin
        // Single-record compare cases; a matching halt terminates with done
        add("exact",         mk(16'h0010,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,1), 0, 1, 16'd1);
        add("rw0_wdata_mask",mk(16'h0010,0,3'd1,16'hFFFF,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,0,3'd1,16'h0000,0,0,16'h0000,16'h0000,1), 0, 1, 16'd1);
        add("rw0_wreg_mask", mk(16'h0010,0,3'd2,16'h0000,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,0,3'd5,16'h0000,0,0,16'h0000,16'h0000,1), 0, 1, 16'd1);
        add("wreg_diff",     mk(16'h0010,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,1,3'd2,16'h0005,0,0,16'h0000,16'h0000,1), 1, 0, 16'd0);
        add("wdata_diff",    mk(16'h0010,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,1,3'd1,16'h0006,0,0,16'h0000,16'h0000,1), 1, 0, 16'd0);
        add("store_mdata",   mk(16'h0010,0,3'd0,16'h0000,0,1,16'h0100,16'h1234,1),
                             mk(16'h0010,0,3'd0,16'h0000,0,1,16'h0100,16'h1235,1), 1, 0, 16'd0);
        add("load_mdata_msk",mk(16'h0010,0,3'd0,16'h0000,1,0,16'h0100,16'h1234,1),
                             mk(16'h0010,0,3'd0,16'h0000,1,0,16'h0100,16'h0000,1), 0, 1, 16'd1);
        add("load_maddr",    mk(16'h0010,0,3'd0,16'h0000,1,0,16'h0100,16'h0000,1),
                             mk(16'h0010,0,3'd0,16'h0000,1,0,16'h0102,16'h0000,1), 1, 0, 16'd0);
        add("nomem_maddr_mk",mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0100,16'h0000,1),
                             mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0200,16'h0000,1), 0, 1, 16'd1);
        add("memwrite_flag", mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,0,3'd0,16'h0000,0,1,16'h0000,16'h0000,1), 1, 0, 16'd0);
        add("halt_diff",     mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,0), 1, 0, 16'd0);
        add("pc_diff",       mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1),
                             mk(16'h0012,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1), 1, 0, 16'd0);
        add("regwrite_flag", mk(16'h0010,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1),
                             mk(16'h0010,1,3'd0,16'h0000,0,0,16'h0000,16'h0000,1), 1, 0, 16'd0);

        for (int i = 0; i < 16; i++) rom[i] = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_cm_ready", cm_ready, 1);
        check("rst_gold_req", gold_req, 0);
        check("rst_gold_addr", gold_addr, 0);
        check("rst_inst_count", inst_count, 0);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_mismatch_idx", mismatch_idx, 0);

        // Table-driven single-record compares
        foreach (vq[i]) begin
            lat = 1;
            do_reset();
            rom[0] = vq[i].gold;
            drive(vq[i].cm);
            wait_end(vq[i].name, 30);
            @(negedge clk);
            check({vq[i].name, "_mismatch"}, mismatch, vq[i].exp_mm);
            check({vq[i].name, "_done"}, done, vq[i].exp_done);
            check({vq[i].name, "_inst_count"}, inst_count, vq[i].exp_cnt);
            check({vq[i].name, "_mismatch_idx"}, mismatch_idx, 0);
        end

        // Three ALU commits then halt, 1-cycle ROM
        lat = 1;
        do_reset();
        rom[0] = mk(16'h0000,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,0);
        rom[1] = mk(16'h0002,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,0);
        rom[2] = mk(16'h0004,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,0);
        rom[3] = mk(16'h0006,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1);
        for (int i = 0; i < 4; i++) drive(rom[i]);
        wait_end("alu_halt", 60);
        repeat (3) @(negedge clk);
        check("alu_inst_count", inst_count, 4);
        check("alu_done", done, 1);
        check("alu_mismatch", mismatch, 0);
        check("alu_req_cnt", req_cnt, 4);
        for (int i = 0; i < 4; i++) check($sformatf("alu_req_addr%0d", i), req_addr[i], i);

        // Store mismatch at index 2, then later commits are ignored
        do_reset();
        rom[0] = mk(16'h0000,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,0);
        rom[1] = mk(16'h0002,1,3'd1,16'h0005,0,0,16'h0000,16'h0000,0);
        rom[2] = mk(16'h0004,0,3'd0,16'h0000,0,1,16'h0200,16'h1234,0);
        rom[3] = mk(16'h0006,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1);
        drive(rom[0]);
        drive(rom[1]);
        drive(mk(16'h0004,0,3'd0,16'h0000,0,1,16'h0200,16'h1235,0));
        wait_end("store", 60);
        @(negedge clk);
        check("store_mismatch", mismatch, 1);
        check("store_mismatch_idx", mismatch_idx, 2);
        check("store_inst_count", inst_count, 2);
        check("store_done", done, 0);
        check("store_ready_term", cm_ready, 1);
        drive(rom[3]);
        drive(rom[3]);
        repeat (20) @(negedge clk);
        check("frozen_mismatch", mismatch, 1);
        check("frozen_mismatch_idx", mismatch_idx, 2);
        check("frozen_inst_count", inst_count, 2);
        check("frozen_done", done, 0);
        check("frozen_req_cnt", req_cnt, 3);
        check("frozen_ready", cm_ready, 1);

        // Slow ROM with back-to-back commits overflows the 4-entry FIFO
        lat = 6;
        do_reset();
        rom[0] = mk(16'h0000,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("ovf_ready%0d", k), cm_ready, (k < 4) ? 1 : 0);
            drive(mk(16'(2*k),0,3'd0,16'h0000,0,0,16'h0000,16'h0000,0));
        end
        check("ovf_mismatch", mismatch, 1);
        check("ovf_mismatch_idx", mismatch_idx, 0);
        repeat (10) @(negedge clk);
        check("ovf_inst_count", inst_count, 0);
        check("ovf_done", done, 0);

        // Reset while waiting on the ROM, then a fresh run from index 0
        lat = 6;
        do_reset();
        rom[0] = mk(16'h0006,0,3'd0,16'h0000,0,0,16'h0000,16'h0000,1);
        drive(rom[0]);
        repeat (3) @(negedge clk);
        check("wait_req_seen", req_cnt, 1);
        check("wait_no_valid_yet", done || mismatch, 0);
        rst = 1'b1;
        #1;
        check("midrst_cm_ready", cm_ready, 1);
        check("midrst_gold_req", gold_req, 0);
        check("midrst_gold_addr", gold_addr, 0);
        check("midrst_inst_count", inst_count, 0);
        check("midrst_done", done, 0);
        check("midrst_mismatch", mismatch, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 1;
        drive(rom[0]);
        wait_end("after_rst", 30);
        @(negedge clk);
        check("after_rst_done", done, 1);
        check("after_rst_inst_count", inst_count, 1);
        check("after_rst_req_cnt", req_cnt, 1);
        check("after_rst_req_addr", req_addr[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
